// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access sizes,
// FUNCT3 codes and the default bus timeout.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    // Codes 011, 110 and 111 have no defined meaning and fall back to word access.
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_BYTE;
            F3_H, F3_HU: f3_size = SZ_HALF;
            default:     f3_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  size_t       size,
    input  logic        sign,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: data = {{24{sign & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sign & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: issues one bus transaction per memory instruction and stalls the core.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses instead of aligning them.
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_rd_en,
    input  logic               mem_wr_en,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        store_data,
    output logic [31:0]        mem_read,
    output logic               stall,
    output logic               bus_err,
    output logic               misalign,
    mem_access_unit_if.master  bus
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg;
    logic        bus_req_reg, bus_we_reg, err_reg;
    logic [31:0] bus_addr_reg, bus_wdata_reg, rdata_reg;
    logic [3:0]  bus_be_reg;
    logic [1:0]  off_reg;
    size_t       size_reg;
    logic        sign_reg, load_reg;

    logic        req, mis_in;
    size_t       size_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in, ext_data;

    assign req     = mem_rd_en | mem_wr_en;
    assign size_in = f3_size(funct3);

    always_comb begin
        be_in = 4'b1111;
        if (!mem_rd_en) begin
            case (size_in)
                SZ_BYTE: be_in = 4'b0001 << addr[1:0];
                SZ_HALF: be_in = 4'b0011 << {addr[1], 1'b0};
                default: be_in = 4'b1111;
            endcase
        end
    end

    // Each byte lane carries the store byte that would land there after alignment.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        always_comb begin
            case (size_in)
                SZ_BYTE: wdata_in[8*gi +: 8] = store_data[7:0];
                SZ_HALF: wdata_in[8*gi +: 8] = store_data[8*(gi%2) +: 8];
                default: wdata_in[8*gi +: 8] = store_data[8*gi +: 8];
            endcase
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_reg;

    assign mis_in = ((size_in == SZ_HALF) && addr[0]) ||
                    ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) mis_reg <= 1'b0;
        else     mis_reg <= (state_reg == IDLE) && req && mis_in;
    end
    assign misalign = mis_reg;
`else
    assign mis_in   = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = req;
                if (req) state_next = mis_in ? DONE : REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (bus.bus_ack || (cnt_reg == TIMEOUT_CNT)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 8'd0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 32'd0;
            bus_wdata_reg <= 32'd0;
            bus_be_reg    <= 4'd0;
            err_reg       <= 1'b0;
            rdata_reg     <= 32'd0;
            off_reg       <= 2'd0;
            size_reg      <= SZ_WORD;
            sign_reg      <= 1'b0;
            load_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= ((state_reg == REQ) && (state_next == REQ)) ? cnt_reg + 8'd1 : 8'd0;
            bus_req_reg <= (state_next == REQ);
            err_reg     <= (state_reg == REQ) && (state_next == DONE) && !bus.bus_ack;
            if ((state_reg == IDLE) && req) begin
                bus_we_reg    <= !mem_rd_en;
                bus_addr_reg  <= {addr[31:2], 2'b00};
                bus_wdata_reg <= wdata_in;
                bus_be_reg    <= be_in;
                off_reg       <= addr[1:0];
                size_reg      <= size_in;
                sign_reg      <= ~funct3[2];
                load_reg      <= mem_rd_en;
                rdata_reg     <= 32'd0;
            end
            // Cleared on issue, so a timed-out load returns zero.
            if ((state_reg == REQ) && bus.bus_ack) rdata_reg <= bus.bus_rdata;
        end
    end

    load_extend u_load_extend (
        .rdata (rdata_reg),
        .off   (off_reg),
        .size  (size_reg),
        .sign  (sign_reg),
        .data  (ext_data)
    );

    assign mem_read      = ((state_reg == DONE) && load_reg) ? ext_data : 32'd0;
    assign bus_err       = err_reg;
    assign bus.bus_req   = bus_req_reg;
    assign bus.bus_we    = bus_we_reg;
    assign bus.bus_addr  = bus_addr_reg;
    assign bus.bus_wdata = bus_wdata_reg;
    assign bus.bus_be    = bus_be_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random loads/stores against a byte-lane reference model.
module tb_mem_access_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_en, mem_wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] mem_read;
    logic        stall, bus_err, misalign;

    int errors = 0;
    int checks = 0;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_read   (mem_read),
        .stall      (stall),
        .bus_err    (bus_err),
        .misalign   (misalign),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int unsigned lane(input logic [2:0] f3, input logic [31:0] a);
        int unsigned n = nbytes(f3);
        int unsigned o = a % 4;
        return o - (o % n);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a, input bit ld);
        int unsigned n = nbytes(f3);
        if (ld) return 4'hF;
        return 4'(((1 << n) - 1) << lane(f3, a));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int unsigned n = nbytes(f3);
        if (n == 1) return (sd % 256) * 32'h0101_0101;
        if (n == 2) return (sd % 65536) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int unsigned n = nbytes(f3);
        logic [31:0] v = rd >> (8 * lane(f3, a));
        bit sgn = (f3 == 3'd0 || f3 == 3'd1);
        if (n == 1) begin
            v = v % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (n == 2) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        int unsigned n = nbytes(f3);
        return (n > 1) && ((a % n) != 0);
`else
        return (f3 === 3'bxxx) && (a === 32'hx);
`endif
    endfunction

    // One memory instruction; waits = ACK-less REQ cycles before ACK (above TMO means never).
    task automatic access(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int waits);
        bit          is_load = ld;
        bit          mis     = model_mis(f3, a);
        bit          err     = !mis && (waits > TMO);
        int          exp_cyc = mis ? 1 : (((waits > TMO) ? TMO : waits) + 2);
        logic [31:0] exp_mr  = (is_load && !mis && !err) ? model_read(f3, a, rd) : 32'd0;
        int          cyc     = 0;
        int          seen    = 0;
        bit          done    = 0;

        @(negedge clk);
        mem_rd_en = ld; mem_wr_en = st; funct3 = f3; addr = a; store_data = sd;
        bus_if.bus_ack = 1'b0;
        #1;
        chk({tag, ".stall_t"}, 32'(stall), 32'd1);
        chk({tag, ".req_t"}, 32'(bus_if.bus_req), 32'd0);

        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!stall) begin
                done = 1;
            end else begin
                seen++;
                chk({tag, ".bus_req"}, 32'(bus_if.bus_req), 32'd1);
                if (seen == 1) begin
                    chk({tag, ".bus_addr"}, bus_if.bus_addr, a & 32'hFFFF_FFFC);
                    chk({tag, ".bus_be"}, 32'(bus_if.bus_be), 32'(model_be(f3, a, is_load)));
                    chk({tag, ".bus_we"}, 32'(bus_if.bus_we), 32'(!is_load));
                    if (!is_load) chk({tag, ".bus_wdata"}, bus_if.bus_wdata, model_wdata(f3, sd));
                end
                if (seen == waits + 1) begin
                    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rd;
                end else begin
                    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
                end
            end
        end
        bus_if.bus_ack = 1'b0;
        chk({tag, ".completed"}, 32'(done), 32'd1);
        chk({tag, ".cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, ".mem_read"}, mem_read, exp_mr);
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(err));
        chk({tag, ".misalign"}, 32'(misalign), 32'(mis));
        chk({tag, ".req_done"}, 32'(bus_if.bus_req), 32'd0);
        if (mis) chk({tag, ".no_bus"}, 32'(seen), 32'd0);
        $display("txn %s ld=%0d st=%0d f3=%0d addr=%h sd=%h rd=%h waits=%0d mem_read=%h cycles=%0d err=%0d",
                 tag, ld, st, f3, a, sd, rd, waits, mem_read, cyc, bus_err);

        // Request held through DONE must not start a second transaction.
        @(negedge clk);
        chk({tag, ".no_reissue"}, 32'(bus_if.bus_req), 32'd0);
        chk({tag, ".err_pulse"}, 32'(bus_err), 32'd0);
        chk({tag, ".mr_idle"}, mem_read, 32'd0);
        mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    endtask

    logic [2:0] ld_codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [2:0] st_codes [4] = '{3'd0, 3'd1, 3'd2, 3'd3};

    initial begin
        rst = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0; funct3 = 3'd0;
        addr = 32'd0; store_data = 32'd0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.mem_read", mem_read, 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.bus_err", 32'(bus_err), 32'd0);
        chk("rst.misalign", 32'(misalign), 32'd0);
        chk("rst.bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst.bus_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst.bus_addr", bus_if.bus_addr, 32'd0);
        chk("rst.bus_be", 32'(bus_if.bus_be), 32'd0);
        chk("rst.bus_wdata", bus_if.bus_wdata, 32'd0);
        rst = 1'b0;

        access("lw_100",  1, 0, 3'd2, 32'h100, 32'h0,        32'hDEAD_BEEF, 0);
        access("lb_103",  1, 0, 3'd0, 32'h103, 32'h0,        32'h80FF_0000, 0);
        access("lbu_103", 1, 0, 3'd4, 32'h103, 32'h0,        32'h80FF_0000, 1);
        access("lh_102",  1, 0, 3'd1, 32'h102, 32'h0,        32'h80FF_0000, 2);
        access("sb_201",  0, 1, 3'd0, 32'h201, 32'h1234_5678, 32'h0,        0);
        access("sh_202",  0, 1, 3'd1, 32'h202, 32'hCAFE_1234, 32'h0,        3);
        access("ld_st",   1, 1, 3'd2, 32'h40C, 32'h5555_5555, 32'h0BAD_F00D, 0);
        access("lw_tmo",  1, 0, 3'd2, 32'h104, 32'h0,        32'h1111_2222, TMO + 1);
        access("lw_edge", 1, 0, 3'd2, 32'h108, 32'h0,        32'h3333_4444, TMO);
        access("lw_102",  1, 0, 3'd2, 32'h102, 32'h0,        32'h7654_3210, 0);

        // Reset during a 3-wait-state REQ abandons the transaction.
        @(negedge clk);
        mem_rd_en = 1'b1; funct3 = 3'd2; addr = 32'h300; bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk("rstmid.bus_req", 32'(bus_if.bus_req), 32'd1);
        @(negedge clk);
        rst = 1'b1; mem_rd_en = 1'b0;
        @(negedge clk);
        chk("rstmid.bus_req_low", 32'(bus_if.bus_req), 32'd0);
        chk("rstmid.stall_low", 32'(stall), 32'd0);
        $display("txn rst_mid_req bus_req=%0d stall=%0d", bus_if.bus_req, stall);
        rst = 1'b0;
        access("lw_after_rst", 1, 0, 3'd2, 32'h300, 32'h0, 32'hA5A5_5A5A, 0);

        for (int i = 0; i < 40; i++) begin
            int          mode  = $urandom_range(0, 2);
            bit          ld    = (mode != 1);
            bit          st    = (mode != 0);
            logic [2:0]  f3    = ld ? ld_codes[$urandom_range(0, 7)] : st_codes[$urandom_range(0, 3)];
            int          waits = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, 3);
            access($sformatf("rnd%0d", i), ld, st, f3, $urandom, $urandom, $urandom, waits);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
